// File: rtl/multdiv_exec_unit_if.sv
// Handshake bundle between the X stage and the iterative multiply/divide unit.
// The unit uses the slave view; the pipeline (or a bench) drives the master view.
interface multdiv_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [4:0]       ctrl_rd;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic [4:0]       result_rd;
    logic             stall;

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_rd,
        output data_result, data_exception, data_resultRDY, result_rd, stall
    );

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_rd,
        input  data_result, data_exception, data_resultRDY, result_rd, stall
    );
endinterface

// File: rtl/multdiv_exec_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit for the X stage.
// One setup cycle converts operands to magnitudes, then WIDTH iterations, then a one-cycle DONE.
module multdiv_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    multdiv_exec_unit_if.slave md
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prep_q, prep_d;
    logic               op_div_q, op_div_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]         rd_q, rd_d;
    logic [WIDTH-1:0]   acc_q, acc_d, lo_q, lo_d, mag_q, mag_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic [4:0]         res_rd_q, res_rd_d;

    logic               start_s;
    logic [WIDTH:0]     sum_s, shifted_s, diff_s;
    logic [WIDTH-1:0]   it_acc_s, it_lo_s, quo_s, fin_res_s;
    logic [2*WIDTH-1:0] prod_s, sprod_s;
    logic               neg_s, fin_exc_s;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign start_s = md.ctrl_MULT | md.ctrl_DIV;

    // One multiply or divide iteration plus the signed fixup of the final iteration's value.
    always_comb begin
        sum_s     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
        shifted_s = {acc_q, lo_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, mag_q};
        if (op_div_q) begin
            if (!diff_s[WIDTH]) begin
                it_acc_s = diff_s[WIDTH-1:0];
                it_lo_s  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                it_acc_s = shifted_s[WIDTH-1:0];
                it_lo_s  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            it_acc_s = sum_s[WIDTH:1];
            it_lo_s  = {sum_s[0], lo_q[WIDTH-1:1]};
        end
        neg_s   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        prod_s  = {it_acc_s, it_lo_s};
        sprod_s = neg_s ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
        quo_s   = neg_s ? (~it_lo_s + WIDTH'(1)) : it_lo_s;
        if (op_div_q) begin
            if (b_q == {WIDTH{1'b0}}) begin
                fin_res_s = {WIDTH{1'b0}};
                fin_exc_s = 1'b1;
            end else begin
                // Only MIN_INT / -1 yields a positive quotient magnitude of 2**(WIDTH-1).
                fin_res_s = quo_s;
                fin_exc_s = ~neg_s & it_lo_s[WIDTH-1];
            end
        end else begin
            fin_res_s = sprod_s[WIDTH-1:0];
            fin_exc_s = (sprod_s[2*WIDTH-1:WIDTH] != {WIDTH{sprod_s[WIDTH-1]}});
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prep_d   = prep_q;
        op_div_d = op_div_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mag_d    = mag_q;
        res_d    = res_q;
        exc_d    = exc_q;
        res_rd_d = res_rd_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d  = BUSY;
                    cnt_d    = {CNT_W{1'b0}};
                    prep_d   = 1'b1;
                    op_div_d = ~md.ctrl_MULT;
                    a_d      = md.data_operandA;
                    b_d      = md.data_operandB;
                    rd_d     = md.ctrl_rd;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (prep_q) begin
                    prep_d = 1'b0;
                    acc_d  = {WIDTH{1'b0}};
                    lo_d   = op_div_q ? abs_val(a_q) : abs_val(b_q);
                    mag_d  = op_div_q ? abs_val(b_q) : abs_val(a_q);
                end else begin
                    acc_d = it_acc_s;
                    lo_d  = it_lo_s;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d  = DONE;
                        res_d    = fin_res_s;
                        exc_d    = fin_exc_s;
                        res_rd_d = rd_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            prep_q   <= 1'b0;
            op_div_q <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            rd_q     <= 5'd0;
            acc_q    <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            mag_q    <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            res_rd_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prep_q   <= prep_d;
            op_div_q <= op_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            mag_q    <= mag_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            res_rd_q <= res_rd_d;
        end
    end

    assign md.data_result    = res_q;
    assign md.data_exception = exc_q;
    assign md.result_rd      = res_rd_q;
    assign md.data_resultRDY = (state_q == DONE);
    // The issuing cycle must already hold the pipeline, hence the combinational start term.
    assign md.stall          = (state_q == BUSY) | ((state_q == IDLE) & start_s);
endmodule

// File: tb/tb_multdiv_exec_unit.sv
// Randomized bench for multdiv_exec_unit with a cycle-level behavioural model and scoreboard.
module tb_multdiv_exec_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    multdiv_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    multdiv_exec_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rst),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: {exception, result}
    function automatic logic [32:0] model(input logic div, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] pv;
        int          q;
        sa = a;
        sb = b;
        if (!div) begin
            p  = longint'(sa) * longint'(sb);
            pv = p;
            return {(p != longint'(int'(pv[31:0]))), pv[31:0]};
        end
        if (sb == 0) return {1'b1, 32'h0000_0000};
        if (a == 32'h8000_0000 && sb == -1) return {1'b1, 32'h8000_0000};
        q = sa / sb;
        return {1'b0, q};
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        k = $urandom_range(0, 4);
        case (k)
            0: return $urandom;
            1: return $unsigned($urandom_range(0, 40)) - 32'd20;
            2: return 32'h0000_0000;
            3: return 32'h8000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Cycle-level model: edges left until the RDY cycle, and whether this is that cycle
    logic [31:0] exp_res;
    logic        exp_exc;
    logic [4:0]  exp_rd;
    int          left;
    bit          done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            left <= 0;
            done <= 1'b0;
        end else if (left > 0) begin
            left <= left - 1;
            done <= (left == 1);
        end else if (done) begin
            done <= 1'b0;
        end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            left <= WIDTH + 1;
            {exp_exc, exp_res} <= model(!bus.ctrl_MULT, bus.data_operandA, bus.data_operandB);
            exp_rd <= bus.ctrl_rd;
        end
    end

    // Compare process: every cycle checks stall/RDY, and the payload in the RDY cycle
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = (left > 0) || (!done && (bus.ctrl_MULT || bus.ctrl_DIV));
        total++;
        if (bus.stall !== exp_stall) begin
            bad++;
            $display("FAIL stall t=%0t: got %b want %b", $time, bus.stall, exp_stall);
        end
        total++;
        if (bus.data_resultRDY !== done) begin
            bad++;
            $display("FAIL rdy t=%0t: got %b want %b", $time, bus.data_resultRDY, done);
        end
        if (done) begin
            total++;
            if (bus.data_result !== exp_res || bus.data_exception !== exp_exc || bus.result_rd !== exp_rd) begin
                bad++;
                $display("FAIL payload t=%0t: got res=%h exc=%b rd=%0d want res=%h exc=%b rd=%0d",
                         $time, bus.data_result, bus.data_exception, bus.result_rd, exp_res, exp_exc, exp_rd);
            end
        end
    end

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ctl bit0 = MULT, bit1 = DIV; lit enables checking against hand-computed values
    task automatic run_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit disturb, input bit lit,
                          input logic [31:0] want_res, input logic want_exc);
        int n;
        @(posedge clk); #1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_rd       = rd;
        bus.ctrl_MULT     = ctl[0];
        bus.ctrl_DIV      = ctl[1];
        @(posedge clk); #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.ctrl_rd       = 5'($urandom);
        if (disturb) begin
            repeat (5) @(posedge clk);
            #1 bus.ctrl_DIV = 1'b1;
            @(posedge clk);
            #1 bus.ctrl_DIV = 1'b0;
        end
        n = 0;
        while (n < 40) begin
            @(negedge clk); #1;
            if (bus.data_resultRDY) break;
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL rdy_timeout: got no RDY within %0d cycles, want one", n);
        end else if (lit) begin
            check("lit_result", {bus.data_exception, bus.data_result}, {want_exc, want_res});
            check("lit_rd", {28'd0, bus.result_rd}, {28'd0, rd});
        end
        if (disturb) bus.ctrl_MULT = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_MULT = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.ctrl_rd       = 5'd0;

        // Pin the model with hand-computed values
        check("model_mul_7x-3",   model(1'b0, 32'd7, 32'hFFFF_FFFD),          {1'b0, 32'hFFFF_FFEB});
        check("model_mul_ovf",    model(1'b0, 32'h4000_0000, 32'd4),          {1'b1, 32'h0000_0000});
        check("model_mul_minint", model(1'b0, 32'hFFFF_0000, 32'd32768),      {1'b0, 32'h8000_0000});
        check("model_div_100/-7", model(1'b1, 32'd100, 32'hFFFF_FFF9),        {1'b0, 32'hFFFF_FFF2});
        check("model_div_-7/2",   model(1'b1, 32'hFFFF_FFF9, 32'd2),          {1'b0, 32'hFFFF_FFFD});
        check("model_div_by0",    model(1'b1, 32'd5, 32'd0),                  {1'b1, 32'h0000_0000});
        check("model_div_minm1",  model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),  {1'b1, 32'h8000_0000});

        #8;
        check("reset_outputs", {bus.stall, bus.data_resultRDY, bus.data_exception, bus.result_rd, bus.data_result},
              {1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b01, 32'd7,          32'hFFFF_FFFD, 5'd3,  1'b0, 1'b1, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b01, 32'h4000_0000,  32'd4,         5'd4,  1'b0, 1'b1, 32'h0000_0000, 1'b1);
        run_op(2'b01, 32'hFFFF_0000,  32'd32768,     5'd5,  1'b0, 1'b1, 32'h8000_0000, 1'b0);
        run_op(2'b10, 32'd100,        32'hFFFF_FFF9, 5'd6,  1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9,  32'd2,         5'd7,  1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b10, 32'd3,          32'd5,         5'd8,  1'b0, 1'b1, 32'h0000_0000, 1'b0);
        run_op(2'b10, 32'd5,          32'd0,         5'd9,  1'b0, 1'b1, 32'h0000_0000, 1'b1);
        run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        run_op(2'b11, 32'd9,          32'd4,         5'd11, 1'b0, 1'b1, 32'd36,        1'b0);
        run_op(2'b01, 32'd12,         32'hFFFF_FFFE, 5'd12, 1'b1, 1'b1, 32'hFFFF_FFE8, 1'b0);

        // Abort mid-operation, then a fresh multiply
        @(posedge clk); #1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd1000;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_MULT = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("reset_abort", {31'd0, bus.stall, bus.data_resultRDY}, 33'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(2'b01, 32'd6, 32'd7, 5'd13, 1'b0, 1'b1, 32'd42, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(1, 3)), rand_op(), rand_op(), 5'($urandom),
                   ($urandom_range(0, 3) == 0), 1'b0, 32'd0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
